// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants, arbiter state type and writability check.
package regfile_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_PC = 5'd15;
    localparam int NUM_SCALAR_REGS = 16;

    typedef enum logic [1:0] {IDLE, HOLD, FORCE} wr_arb_state_t;

    function automatic logic is_writable_scalar(input logic [4:0] addr);
        return !addr[4] && (addr != REG_ZERO) && (addr != REG_PC);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between writeback and an external producer.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int N = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wb_we,
    input  logic [4:0]   wb_addr,
    input  logic [N-1:0] wb_data,
    input  logic         ext_valid,
    input  logic [4:0]   ext_addr,
    input  logic [N-1:0] ext_data,
    output logic         ext_ready,
    output logic         rf_we,
    output logic [4:0]   rf_addr,
    output logic [N-1:0] rf_data,
    output logic         stall_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);
    localparam logic [CW-1:0] FORCE_AT = CW'(MAX_WAIT - 1);

    wr_arb_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [4:0]    hold_addr_q, hold_addr_d;
    logic [N-1:0]  hold_data_q, hold_data_d;
    logic          stall_q, stall_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_addr_q, rf_addr_d;
    logic [N-1:0]  rf_data_q, rf_data_d;
    logic          grant_wb, grant_hold;
    logic [4:0]    sel_addr;
    logic [N-1:0]  sel_data;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        stall_d = 1'b0;
        grant_wb = 1'b0;
        grant_hold = 1'b0;
        case (state_q)
            IDLE: begin
                grant_wb = wb_we;
                if (ext_valid) begin
                    hold_addr_d = ext_addr;
                    hold_data_d = ext_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!wb_we) begin
                    grant_hold = 1'b1;
                    cnt_d = '0;
                    state_d = IDLE;
                end else begin
                    grant_wb = 1'b1;
                    cnt_d = cnt_inc;
                    // Stall is registered so the pipeline freezes in the cycle the held write wins.
                    if (cnt_inc >= FORCE_AT) begin
                        stall_d = 1'b1;
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                grant_hold = 1'b1;
                cnt_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        sel_addr = grant_hold ? hold_addr_q : wb_addr;
        sel_data = grant_hold ? hold_data_q : wb_data;
        rf_we_d = (grant_wb || grant_hold) && is_writable_scalar(sel_addr);
        rf_addr_d = rf_we_d ? sel_addr : rf_addr_q;
        rf_data_d = rf_we_d ? sel_data : rf_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            stall_q <= 1'b0;
            rf_we_q <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            stall_q <= stall_d;
            rf_we_q <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign ext_ready = (state_q == IDLE);
    assign stall_o = stall_q;
    assign rf_we = rf_we_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vector table plus hand sequences for reset, starvation and collision.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ext_valid = 1'b0;
    logic [4:0]  ext_addr = '0;
    logic [31:0] ext_data = '0;
    logic        ext_ready, rf_we, stall_o;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        ext_valid;
        logic [4:0]  ext_addr;
        logic [31:0] ext_data;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ready;
    } vec_t;

    vec_t vecs[10];

    regfile_write_arbiter #(.N(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ext_valid(ext_valid), .ext_addr(ext_addr), .ext_data(ext_data),
        .ext_ready(ext_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ev, input logic [4:0] ea, input logic [31:0] ed);
        wb_we = we;
        wb_addr = wa;
        wb_data = wd;
        ext_valid = ev;
        ext_addr = ea;
        ext_data = ed;
    endtask

    task automatic expect_rf(input string name, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({name, "_we"}, 32'(rf_we), 32'(we));
        if (we) begin
            chk({name, "_addr"}, 32'(rf_addr), 32'(a));
            chk({name, "_data"}, rf_data, d);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd4,  32'h1234, 1'b0, 5'd0,  32'h0,    1'b1, 5'd4,  32'h1234, 1'b1};
        vecs[1] = '{1'b1, 5'd0,  32'h55,   1'b0, 5'd0,  32'h0,    1'b0, 5'd4,  32'h1234, 1'b1};
        vecs[2] = '{1'b1, 5'd15, 32'h66,   1'b0, 5'd0,  32'h0,    1'b0, 5'd4,  32'h1234, 1'b1};
        vecs[3] = '{1'b1, 5'd16, 32'h77,   1'b0, 5'd0,  32'h0,    1'b0, 5'd4,  32'h1234, 1'b1};
        vecs[4] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd6,  32'hBEEF, 1'b0, 5'd4,  32'h1234, 1'b0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd6,  32'hBEEF, 1'b1};
        vecs[6] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'h12, 32'h99,   1'b0, 5'd6,  32'hBEEF, 1'b0};
        vecs[7] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd6,  32'hBEEF, 1'b1};
        vecs[8] = '{1'b1, 5'd9,  32'hA,    1'b1, 5'd10, 32'hB,    1'b1, 5'd9,  32'hA,    1'b0};
        vecs[9] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd10, 32'hB,    1'b1};

        #2;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_addr", 32'(rf_addr), 32'd0);
        chk("rst_data", rf_data, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_ready", 32'(ext_ready), 32'd1);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].wb_we, vecs[i].wb_addr, vecs[i].wb_data,
                  vecs[i].ext_valid, vecs[i].ext_addr, vecs[i].ext_data);
            tick();
            chk($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_addr", i), 32'(rf_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_data", i), rf_data, vecs[i].e_data);
            chk($sformatf("v%0d_ready", i), 32'(ext_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'd0);
        end

        // Starvation: ext r7 accepted while writeback keeps the port busy.
        drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd7, 32'h77);
        tick();
        expect_rf("st0", 1'b1, 5'd1, 32'h100);
        chk("st0_ready", 32'(ext_ready), 32'd0);
        drive(1'b1, 5'd2, 32'h200, 1'b0, 5'd0, 32'h0);
        tick();
        expect_rf("st1", 1'b1, 5'd2, 32'h200);
        chk("st1_stall", 32'(stall_o), 32'd0);
        drive(1'b1, 5'd3, 32'h300, 1'b0, 5'd0, 32'h0);
        tick();
        expect_rf("st2", 1'b1, 5'd3, 32'h300);
        chk("st2_stall", 32'(stall_o), 32'd0);
        drive(1'b1, 5'd4, 32'h400, 1'b0, 5'd0, 32'h0);
        tick();
        expect_rf("st3", 1'b1, 5'd4, 32'h400);
        chk("st4_stall", 32'(stall_o), 32'd1);
        drive(1'b1, 5'd5, 32'h500, 1'b0, 5'd0, 32'h0);
        tick();
        expect_rf("st5", 1'b1, 5'd7, 32'h77);
        chk("st5_stall", 32'(stall_o), 32'd0);
        chk("st5_ready", 32'(ext_ready), 32'd1);
        tick();
        expect_rf("st6", 1'b1, 5'd5, 32'h500);

        // Collision: held ext r8=1 loses to wb r8=2, then commits last.
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h1);
        tick();
        drive(1'b1, 5'd8, 32'h2, 1'b0, 5'd0, 32'h0);
        tick();
        expect_rf("col_wb", 1'b1, 5'd8, 32'h2);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        expect_rf("col_ext", 1'b1, 5'd8, 32'h1);
        tick();
        chk("col_idle_we", 32'(rf_we), 32'd0);
        chk("col_final", rf_data, 32'h1);

        // Reset while a write is held: it must never commit.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAA);
        tick();
        chk("rh_ready", 32'(ext_ready), 32'd0);
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("rh_rst_we", 32'(rf_we), 32'd0);
        chk("rh_rst_addr", 32'(rf_addr), 32'd0);
        chk("rh_rst_ready", 32'(ext_ready), 32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rh_post%0d_we", i), 32'(rf_we), 32'd0);
            chk($sformatf("rh_post%0d_ready", i), 32'(ext_ready), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
